// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator datapath.
// Sign-magnitude operands: MSB is the sign.
package calc_pkg;

  localparam int MAG_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ITER,
    DONE
  } state_t;

  function automatic logic sm_zero_fix(
    input logic sign,
    input logic mag_zero
  );
    return sign & ~mag_zero;
  endfunction

endpackage

// File: rtl/divrem_step.sv
// One restoring divide step: shift {prem, qreg} left,
// then subtract the divisor when it fits.
module divrem_step #(
  parameter int MAG_W = 2
) (
  input  logic [MAG_W-1:0] prem_in,
  input  logic [MAG_W-1:0] qreg_in,
  input  logic [MAG_W-1:0] divisor,
  output logic [MAG_W:0]   prem_out,
  output logic [MAG_W-1:0] qreg_out
);

  logic [MAG_W:0] sh;
  logic           ge;

  // one extra bit so the shift never overflows
  assign sh = {prem_in, qreg_in[MAG_W-1]};
  assign ge = sh >= {1'b0, divisor};

  assign prem_out = ge ? sh - {1'b0, divisor} : sh;
  assign qreg_out = (qreg_in << 1) | MAG_W'(ge);

endmodule

// File: rtl/divrem_seq.sv
// Sequential sign-magnitude divide/remainder unit,
// one quotient bit per clock with busy/done handshake.
module divrem_seq
  import calc_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [MAG_W:0] a,
  input  logic [MAG_W:0] b,
  output logic           busy,
  output logic           done,
  output logic [MAG_W:0] q,
  output logic [MAG_W:0] r,
  output logic           sf,
  output logic           zf,
  output logic           DZf
);

  localparam int CW = (MAG_W > 1) ? $clog2(MAG_W) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             sa;
  logic             sb;
  logic [MAG_W-1:0] amag;
  logic [MAG_W-1:0] bmag;
  logic [MAG_W-1:0] prem;
  logic [MAG_W-1:0] qreg;
  logic [MAG_W:0]   p_nxt;
  logic [MAG_W-1:0] q_nxt;

  divrem_step #(
    .MAG_W(MAG_W)
  ) u_step (
    .prem_in (prem),
    .qreg_in (qreg),
    .divisor (bmag),
    .prem_out(p_nxt),
    .qreg_out(q_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      amag  <= '0;
      bmag  <= '0;
      prem  <= '0;
      qreg  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      sf    <= 1'b0;
      zf    <= 1'b0;
      DZf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a[MAG_W];
            sb    <= b[MAG_W];
            amag  <= a[MAG_W-1:0];
            bmag  <= b[MAG_W-1:0];
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (bmag == '0) begin
            q     <= '0;
            r     <= '0;
            sf    <= sa;
            zf    <= 1'b1;
            DZf   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            prem  <= '0;
            qreg  <= amag;
            cnt   <= CW'(MAG_W - 1);
            state <= ITER;
          end
        end
        ITER: begin
          prem <= p_nxt[MAG_W-1:0];
          qreg <= q_nxt;
          if (cnt == '0) begin
            q <= {sm_zero_fix(sa ^ sb, q_nxt == '0),
                  q_nxt};
            r <= {sm_zero_fix(sa, p_nxt == '0),
                  p_nxt[MAG_W-1:0]};
            sf    <= sa;
            zf    <= (p_nxt == '0);
            DZf   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divrem_seq.sv
// Bench for divrem_seq: vector table through a scoreboard,
// plus busy/ignore-start and mid-operation reset sequences.
module tb_divrem_seq;

  localparam int MAG_W = 2;
  localparam int W     = MAG_W + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         sf;
    logic         zf;
    logic         dz;
    int           lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         sf;
  logic         zf;
  logic         dz;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  localparam int NV = 11;
  vec_t tbl [NV];
  vec_t prev;

  divrem_seq #(.MAG_W(MAG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a_i),
    .b    (b_i),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .sf   (sf),
    .zf   (zf),
    .DZf  (dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done=1 want 0 (cyc %0d)",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q", 32'(q), 32'(e.v.q));
        chk("r", 32'(r), 32'(e.v.r));
        chk("sf", 32'(sf), 32'(e.v.sf));
        chk("zf", 32'(zf), 32'(e.v.zf));
        chk("dzf", 32'(dz), 32'(e.v.dz));
        chk("latency", 32'(cyc), 32'(e.due));
        chk("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    a_i   = v.a;
    b_i   = v.b;
    start = 1'b1;
    e.v   = v;
    e.due = cyc + v.lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
  endtask

  initial begin
    tbl = '{
      '{3'b011, 3'b010, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 4},
      '{3'b111, 3'b010, 3'b101, 3'b101, 1'b1, 1'b0, 1'b0, 4},
      '{3'b011, 3'b101, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 4},
      '{3'b100, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 4},
      '{3'b010, 3'b100, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 2},
      '{3'b001, 3'b011, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 4},
      '{3'b110, 3'b110, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 4},
      '{3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1, 2},
      '{3'b101, 3'b011, 3'b000, 3'b101, 1'b1, 1'b0, 1'b0, 4},
      '{3'b011, 3'b111, 3'b101, 3'b000, 1'b0, 1'b1, 1'b0, 4},
      '{3'b011, 3'b001, 3'b011, 3'b000, 1'b0, 1'b1, 1'b0, 4}
    };

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_flags", 32'({sf, zf, dz}), 32'd0);

    for (int i = 0; i < NV; i++) run_op(tbl[i]);

    // start re-pulsed while busy and during DONE
    prev = tbl[NV-1];
    begin
      exp_t e;
      a_i   = 3'b011;
      b_i   = 3'b010;
      start = 1'b1;
      e.v   = tbl[0];
      e.due = cyc + 4;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 1; k <= 4; k++) begin
      a_i   = 3'b001;
      b_i   = 3'b001;
      start = 1'b1;
      chk("busy_run", 32'(busy), 32'd1);
      if (k < 4) begin
        chk("q_hold", 32'(q), 32'(prev.q));
        chk("r_hold", 32'(r), 32'(prev.r));
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("busy_fall", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_quiet", 32'(busy), 32'd0);
    chk("one_done", 32'(sb.size()), 32'd0);
    chk("q_after", 32'(q), 32'b001);
    chk("r_after", 32'(r), 32'b001);
    sb.delete();

    // reset during ITER aborts without a done
    a_i   = 3'b011;
    b_i   = 3'b010;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    chk("abort_flags", 32'({sf, zf, dz}), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    run_op(tbl[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
